// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment read-back block: the active-low
// segment codes of every displayable digit plus blank, and the FSM states.
package seg7_pkg;

  // Active-low patterns, bit 6 = segment a ... bit 0 = segment g.
  localparam logic [6:0] SEG_0     = 7'h01;
  localparam logic [6:0] SEG_1     = 7'h4F;
  localparam logic [6:0] SEG_2     = 7'h12;
  localparam logic [6:0] SEG_3     = 7'h06;
  localparam logic [6:0] SEG_4     = 7'h4C;
  localparam logic [6:0] SEG_5     = 7'h24;
  localparam logic [6:0] SEG_6     = 7'h20;
  localparam logic [6:0] SEG_7     = 7'h0F;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h04;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h60;
  localparam logic [6:0] SEG_C     = 7'h31;
  localparam logic [6:0] SEG_D     = 7'h42;
  localparam logic [6:0] SEG_E     = 7'h30;
  localparam logic [6:0] SEG_F     = 7'h38;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // SETTLE: waiting for a new qualified pattern; PRESENT: result offered.
  typedef enum logic {
    SETTLE  = 1'b0,
    PRESENT = 1'b1
  } seg7_cap_state_t;

endpackage

// File: rtl/seg7_encode.sv
// Purely combinational lookup from an active-low segment pattern to the hex
// digit it shows, with blank and illegal-pattern flags.
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] hex_o,
  output logic       blank_o,
  output logic       err_o
);

  // Table lookup; anything that is not a digit or blank is an error with hex 0.
  always_comb begin
    hex_o   = 4'h0;
    blank_o = 1'b0;
    err_o   = 1'b0;
    case (seg_i)
      SEG_0:     hex_o = 4'h0;
      SEG_1:     hex_o = 4'h1;
      SEG_2:     hex_o = 4'h2;
      SEG_3:     hex_o = 4'h3;
      SEG_4:     hex_o = 4'h4;
      SEG_5:     hex_o = 4'h5;
      SEG_6:     hex_o = 4'h6;
      SEG_7:     hex_o = 4'h7;
      SEG_8:     hex_o = 4'h8;
      SEG_9:     hex_o = 4'h9;
      SEG_A:     hex_o = 4'hA;
      SEG_B:     hex_o = 4'hB;
      SEG_C:     hex_o = 4'hC;
      SEG_D:     hex_o = 4'hD;
      SEG_E:     hex_o = 4'hE;
      SEG_F:     hex_o = 4'hF;
      SEG_BLANK: blank_o = 1'b1;
      default:   err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// Seven-segment read-back: synchronizes the segment pins, waits until a
// pattern has been stable long enough, decodes each newly stable pattern and
// offers it on a valid/ready handshake.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Sa,
  input  logic       Sb,
  input  logic       Sc,
  input  logic       Sd,
  input  logic       Se,
  input  logic       Sf,
  input  logic       Sg,
  input  logic       ready,
  output logic [3:0] hex,
  output logic       valid,
  output logic       blank,
  output logic       err
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  logic [6:0]      seg_s;
  logic [6:0]      s1_q;
  logic [6:0]      s2_q;
  logic [7:0]      cnt_q;
  logic [7:0]      cnt_d;
  logic            qualified_s;
  logic            new_pattern_s;
  logic [6:0]      last_rep_q;
  logic            rep_ok_q;
  seg7_cap_state_t state_q;
  logic [3:0]      hex_q;
  logic            blank_q;
  logic            err_q;
  logic            valid_q;
  logic [3:0]      enc_hex_s;
  logic            enc_blank_s;
  logic            enc_err_s;

  assign seg_s = {Sa, Sb, Sc, Sd, Se, Sf, Sg};

  // Two-flop synchronizer; idles at all-segments-off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= SEG_BLANK;
      s2_q <= SEG_BLANK;
    end else begin
      s1_q <= seg_s;
      s2_q <= s1_q;
    end
  end

  // Stability count: s1 is the value s2 takes next, so a mismatch means s2
  // changes on this edge and the run restarts; otherwise count up to the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (s1_q != s2_q) begin
      cnt_d = 8'd0;
    end else if (cnt_q < STABLE_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = STABLE_MAX;
    end
  end

  // Stability counter register, running in every FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The pattern is qualified on the edge where its run reaches the limit;
  // only a pattern different from the last report (or the first) is offered.
  assign qualified_s   = (cnt_d == STABLE_MAX);
  assign new_pattern_s = !rep_ok_q || (s2_q != last_rep_q);

  seg7_encode u_encode (
    .seg_i   (s2_q),
    .hex_o   (enc_hex_s),
    .blank_o (enc_blank_s),
    .err_o   (enc_err_s)
  );

  // Report FSM with registered result, last-report memory and handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SETTLE;
      valid_q    <= 1'b0;
      hex_q      <= 4'h0;
      blank_q    <= 1'b0;
      err_q      <= 1'b0;
      last_rep_q <= SEG_BLANK;
      rep_ok_q   <= 1'b0;
    end else begin
      case (state_q)
        SETTLE: begin
          if (qualified_s && new_pattern_s) begin
            state_q    <= PRESENT;
            valid_q    <= 1'b1;
            hex_q      <= enc_hex_s;
            blank_q    <= enc_blank_s;
            err_q      <= enc_err_s;
            last_rep_q <= s2_q;
            rep_ok_q   <= 1'b1;
          end else begin
            state_q <= SETTLE;
            valid_q <= 1'b0;
          end
        end
        PRESENT: begin
          if (valid_q && ready) begin
            state_q <= SETTLE;
            valid_q <= 1'b0;
          end else begin
            state_q <= PRESENT;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= SETTLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign hex   = hex_q;
  assign valid = valid_q;
  assign blank = blank_q;
  assign err   = err_q;

endmodule
